bcd_to_bin_pulse: RTL and testbench
===================================

// Module: bcd_to_bin_pulse
//
// PURPOSE
//   Consumer side of bcd_counter_pulse: accepts a packed BCD word qualified by
//   a one-cycle 'updated' strobe and converts it to binary, digit-serial, MSD
//   first (acc = acc*10 + digit). Emits a one-cycle 'valid' with the result.
//   One-deep pending buffer absorbs strobes that arrive while a conversion runs.
//
// PARAMETERS
//   WIDTH       8  binary result width; saturation limit is 2**WIDTH-1
//   BCD_DIGITS  3  number of BCD digits on 'bcd' (digit 0 = bcd[3:0], LSD)
//
// PORTS
//   clk      in   1             clock, all state on rising edge
//   rst      in   1             asynchronous, active-low reset (rst==0 resets)
//   bcd      in   BCD_DIGITS*4  packed BCD operand, sampled only when updated==1
//   updated  in   1             one-cycle strobe: bcd holds a new value
//   bin      out  WIDTH         last converted value, held until next result
//   valid    out  1             one-cycle pulse: bin/error just updated
//   error    out  1             last result invalid (digit>9 or value>2**WIDTH-1)
//   busy     out  1             1 in CONV and DONE states
//
// BEHAVIOUR
//   Reset (rst low, async): bin=0, valid=0, error=0, busy=0, state=IDLE,
//     pending flag cleared, in-flight conversion aborted, nothing emitted.
//   FSM IDLE -> CONV -> DONE -> IDLE|CONV.
//   IDLE: updated==1 -> capture bcd into work reg, acc=0, err_acc=0,
//     idx=BCD_DIGITS-1, go CONV.
//   CONV: one digit per cycle, idx from BCD_DIGITS-1 down to 0:
//     acc <= acc*10 + digit[idx]  (acc*10 = (acc<<3)+(acc<<1));
//     acc is WIDTH+4 bits; set err_acc if digit>9 or acc > 2**WIDTH-1 after
//     the step (sticky); after idx==0 processed -> DONE.
//   DONE (single cycle): valid=1; if err_acc: bin=2**WIDTH-1 (saturate),
//     error=1; else bin=acc[WIDTH-1:0], error=0. Next state: CONV if pending
//     (load pending value, clear pending) else IDLE.
//   Latency: updated sampled at edge N -> valid high in cycle N+BCD_DIGITS+1;
//     min spacing between results BCD_DIGITS+1 cycles.
//   Strobe while busy (CONV or DONE): bcd copied into pending reg, pending=1;
//     a further strobe before it is consumed overwrites it (latest wins);
//     earlier dropped value never produces a valid.
//   updated in the DONE cycle is captured into pending and converted next.
//   valid is never asserted two cycles in a row; bin/error change only with valid.
//   bcd is ignored when updated==0; X on bcd with updated==0 is harmless.
//
// TESTING  (WIDTH=8, BCD_DIGITS=3, rst released after 10 ns, 10 ns clock)
//   1. updated with bcd=12'h012 -> valid 4 cycles later, bin=12, error=0, busy 3+1 cycles.
//   2. bcd=12'h255 -> bin=255, error=0; then bcd=12'h256 -> bin=255, error=1.
//   3. bcd=12'h0A3 (digit 10) -> bin=255, error=1; next bcd=12'h001 -> bin=1, error=0.
//   4. Strobes 12'h007 @t0, 12'h008 @t0+2, 12'h009 @t0+3 -> exactly two valids:
//      bin=7 then bin=9 (8 overwritten), second valid back-to-back via DONE->CONV.
//   5. rst low during CONV second digit -> all outputs 0 at once, no valid; after
//      release, bcd=12'h100 -> bin=100, error=0.
//   6. Driven by bcd_counter_pulse (MIN 0, MAX 12, CLOCKS_PER_INCREMENT 3) with
//      random resets -> every valid's bin equals counter value at its strobe,
//      sequence 0..12 wrapping, error never set.

Source files
------------

// File: rtl/bcd_to_bin_pulse.sv
// bcd_to_bin_pulse: digit-serial BCD to binary converter (MSD first).
// One-deep pending buffer absorbs strobes that arrive while converting.
module bcd_to_bin_pulse #(
    parameter int WIDTH      = 8,
    parameter int BCD_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BCD_DIGITS*4-1:0] bcd,
    input  logic                    updated,
    output logic [WIDTH-1:0]        bin,
    output logic                    valid,
    output logic                    error,
    output logic                    busy
);

    localparam int BW = BCD_DIGITS * 4;
    localparam int AW = WIDTH + 4;
    localparam int IW = (BCD_DIGITS > 1) ? $clog2(BCD_DIGITS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [AW-1:0] LIMIT   = {4'b0000, {WIDTH{1'b1}}};
    localparam logic [IW-1:0] IDX_TOP = IW'(BCD_DIGITS - 1);

    logic [1:0]    state;
    logic [BW-1:0] work;
    logic [BW-1:0] pend_val;
    logic          pend;
    logic [AW-1:0] acc;
    logic          err_acc;
    logic [IW-1:0] idx;

    logic [3:0]    digit;
    logic [AW-1:0] acc_next;
    logic          step_err;
    logic          start;
    logic [BW-1:0] start_val;

    assign busy = (state != S_IDLE);

    // Datapath step: the most significant unconsumed digit sits at the top of work
    always_comb begin
        digit     = work[BW-1 -: 4];
        acc_next  = (acc << 3) + (acc << 1) + {{WIDTH{1'b0}}, digit};
        step_err  = err_acc | (digit > 4'd9) | (acc_next > LIMIT);
        start     = 1'b0;
        start_val = pend_val;
        if (state == S_IDLE) begin
            start     = updated;
            start_val = bcd;
        end else if (state == S_DONE) begin
            // A strobe in the DONE cycle is newer than any pending value
            start     = updated | pend;
            start_val = updated ? bcd : pend_val;
        end
    end

    // Pending buffer: latest strobe seen while busy, consumed when DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend     <= 1'b0;
            pend_val <= '0;
        end else if (state == S_DONE) begin
            pend <= 1'b0;
        end else if (state == S_CONV && updated) begin
            pend     <= 1'b1;
            pend_val <= bcd;
        end
    end

    // Conversion FSM and registered result outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            work    <= '0;
            acc     <= '0;
            err_acc <= 1'b0;
            idx     <= '0;
            bin     <= '0;
            valid   <= 1'b0;
            error   <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        work    <= start_val;
                        acc     <= '0;
                        err_acc <= 1'b0;
                        idx     <= IDX_TOP;
                        state   <= S_CONV;
                    end
                end
                S_CONV: begin
                    acc     <= acc_next;
                    err_acc <= step_err;
                    work    <= work << 4;
                    if (idx == '0) begin
                        state <= S_DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                S_DONE: begin
                    valid <= 1'b1;
                    if (err_acc) begin
                        bin   <= {WIDTH{1'b1}};
                        error <= 1'b1;
                    end else begin
                        bin   <= acc[WIDTH-1:0];
                        error <= 1'b0;
                    end
                    if (start) begin
                        work    <= start_val;
                        acc     <= '0;
                        err_acc <= 1'b0;
                        idx     <= IDX_TOP;
                        state   <= S_CONV;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_pulse.sv
// tb_bcd_to_bin_pulse: scoreboard bench for bcd_to_bin_pulse.
// Stimulus pushes expected {error,bin}; a monitor pops on every valid.
module tb_bcd_to_bin_pulse;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] bcd = '0;
    logic        updated = 1'b0;
    logic [7:0]  bin;
    logic        valid;
    logic        error;
    logic        busy;

    int tests = 0;
    int fails = 0;

    logic [8:0] sb[$];
    logic [8:0] exp_r;
    logic       prev_valid = 1'b0;

    always #5 clk = ~clk;

    bcd_to_bin_pulse #(.WIDTH(8), .BCD_DIGITS(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .bcd     (bcd),
        .updated (updated),
        .bin     (bin),
        .valid   (valid),
        .error   (error),
        .busy    (busy)
    );

    // Monitor: compare every result against the head of the scoreboard
    always @(negedge clk) begin
        if (valid) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_valid bin=%0d error=%0b, nothing expected",
                         bin, error);
            end else begin
                exp_r = sb.pop_front();
                if ({error, bin} !== exp_r || prev_valid) begin
                    fails++;
                    $display("FAIL result got bin=%0d error=%0b back2back=%0b want bin=%0d error=%0b",
                             bin, error, prev_valid, exp_r[7:0], exp_r[8]);
                end
            end
        end
        prev_valid = valid;
    end

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic issue(input logic [11:0] v, input logic [7:0] eb,
                         input logic ee, input bit push);
        bcd     = v;
        updated = 1'b1;
        if (push) sb.push_back({ee, eb});
        @(negedge clk);
        updated = 1'b0;
        bcd     = 'x;
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0 && !busy && !valid) begin
                done = 1'b1;
                break;
            end
        end
        check({name, "_drain"}, int'(done), 1);
    endtask

    task automatic wait_valid(output int cycles);
        cycles = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (valid) begin
                cycles = c;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int lat;
        int busy_cnt;
        int gap;
        int cnt;
        int rst_at;
        logic [11:0] v;

        #7;
        check("reset_bin", int'(bin), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_error", int'(error), 0);
        check("reset_busy", int'(busy), 0);
        #3;
        rst = 1'b1;
        @(negedge clk);

        // 1: latency and busy duration
        issue(12'h012, 8'd12, 1'b0, 1'b1);
        busy_cnt = int'(busy);
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (valid) begin
                lat = c;
                break;
            end
            if (busy) busy_cnt++;
        end
        check("t1_latency", lat, 4);
        check("t1_busy_cycles", busy_cnt, 4);
        drain("t1");

        // 2: largest legal value, then first overflowing value
        issue(12'h255, 8'd255, 1'b0, 1'b1);
        drain("t2a");
        issue(12'h256, 8'd255, 1'b1, 1'b1);
        drain("t2b");
        check("t2_hold_bin", int'(bin), 255);
        check("t2_hold_error", int'(error), 1);

        // 3: illegal digit, then recovery
        issue(12'h0A3, 8'd255, 1'b1, 1'b1);
        drain("t3a");
        issue(12'h001, 8'd1, 1'b0, 1'b1);
        drain("t3b");
        check("t3_hold_error", int'(error), 0);

        // 4: pending overwrite, latest wins, back-to-back results
        issue(12'h007, 8'd7, 1'b0, 1'b1);
        @(negedge clk);
        issue(12'h008, 8'd0, 1'b0, 1'b0);
        issue(12'h009, 8'd9, 1'b0, 1'b1);
        wait_valid(lat);
        check("t4_first_valid", lat, 1);
        wait_valid(gap);
        check("t4_result_gap", gap, 4);
        drain("t4");

        // 5: reset mid-conversion aborts and clears outputs at once
        issue(12'h123, 8'd123, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        sb.delete();
        check("t5_rst_bin", int'(bin), 0);
        check("t5_rst_valid", int'(valid), 0);
        check("t5_rst_error", int'(error), 0);
        check("t5_rst_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        issue(12'h100, 8'd100, 1'b0, 1'b1);
        drain("t5");
        check("t5_bin", int'(bin), 100);

        // 6: counter-like source 0..12 wrapping, with one reset mid-stream
        cnt    = 0;
        rst_at = int'($urandom_range(5, 20));
        for (int k = 0; k < 30; k++) begin
            if (k == rst_at) begin
                rst = 1'b0;
                sb.delete();
                @(negedge clk);
                rst = 1'b1;
                cnt = 0;
            end
            v = {4'h0, 4'(cnt / 10), 4'(cnt % 10)};
            issue(v, 8'(cnt), 1'b0, 1'b1);
            repeat (3) @(negedge clk);
            cnt = (cnt == 12) ? 0 : cnt + 1;
        end
        drain("t6");
        check("t6_error_clear", int'(error), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
